// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: state encoding, timing
// defaults, synchronizer bundle and frame construction helpers.
package ps2_pkg;
    localparam int FRAME_LEN              = 10;
    localparam int DEF_CLK_INHIBIT_CYCLES = 6000;
    localparam int DEF_DATA_SETUP_CYCLES  = 100;
    localparam int DEF_FIRST_EDGE_TIMEOUT = 750000;
    localparam int DEF_TRANSFER_TIMEOUT   = 100000;
    localparam int DEF_TIMER_WIDTH        = 20;

    typedef logic [7:0]           cmd_byte_t;
    typedef logic [FRAME_LEN-1:0] frame_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INHIBIT   = 4'd1,
        ST_RTS       = 4'd2,
        ST_WAIT_EDGE = 4'd3,
        ST_TX        = 4'd4,
        ST_WAIT_ACK  = 4'd5,
        ST_WAIT_IDLE = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERR       = 4'd8
    } tx_state_e;

    typedef struct packed {
        logic clk;
        logic dat;
        logic clk_fall;
        logic clk_rise;
        logic dat_fall;
        logic dat_rise;
    } line_sync_t;

    function automatic logic odd_parity(input cmd_byte_t data);
        return ~(^data);
    endfunction

    // Bit 0 is the first data bit; the start bit is driven separately.
    function automatic frame_t build_frame(input cmd_byte_t data);
        return {1'b1, odd_parity(data), data};
    endfunction
endpackage

// File: rtl/ps2_command_out_if.sv
// Command handshake between keyboard/mouse init logic (master) and the
// PS/2 host transmitter (slave).
interface ps2_command_out_if;
    import ps2_pkg::*;

    cmd_byte_t the_command;
    logic      send_command;
    logic      busy;
    logic      command_was_sent;
    logic      error_communication_timed_out;

    modport master (
        output the_command, send_command,
        input  busy, command_was_sent, error_communication_timed_out
    );

    modport slave (
        input  the_command, send_command,
        output busy, command_was_sent, error_communication_timed_out
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for PS2_CLK/PS2_DAT with edge detection on both lines;
// shared with the receive controller.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output line_sync_t sync_o
);
    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] dat_sync_q, dat_sync_d;
    logic       clk_prev_q, clk_prev_d;
    logic       dat_prev_q, dat_prev_d;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_i};
        dat_sync_d = {dat_sync_q[0], ps2_dat_i};
        clk_prev_d = clk_sync_q[1];
        dat_prev_d = dat_sync_q[1];
    end

    // Idle bus level is high, so everything resets to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            dat_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_prev_q <= dat_prev_d;
        end
    end

    always_comb begin
        sync_o.clk      = clk_sync_q[1];
        sync_o.dat      = dat_sync_q[1];
        sync_o.clk_fall = ~clk_sync_q[1] & clk_prev_q;
        sync_o.clk_rise = clk_sync_q[1] & ~clk_prev_q;
        sync_o.dat_fall = ~dat_sync_q[1] & dat_prev_q;
        sync_o.dat_rise = dat_sync_q[1] & ~dat_prev_q;
    end
endmodule

// File: rtl/ps2_command_out.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out one
// command frame on device clock edges, then check the device ACK.
module ps2_command_out
    import ps2_pkg::*;
#(
    parameter int CLK_INHIBIT_CYCLES = DEF_CLK_INHIBIT_CYCLES,
    parameter int DATA_SETUP_CYCLES  = DEF_DATA_SETUP_CYCLES,
    parameter int FIRST_EDGE_TIMEOUT = DEF_FIRST_EDGE_TIMEOUT,
    parameter int TRANSFER_TIMEOUT   = DEF_TRANSFER_TIMEOUT,
    parameter int TIMER_WIDTH        = DEF_TIMER_WIDTH
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    inout  wire                  PS2_CLK,
    inout  wire                  PS2_DAT,
    ps2_command_out_if.slave     cmd_if
);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO   = {TIMER_WIDTH{1'b0}};
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX    = {TIMER_WIDTH{1'b1}};
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE    = TIMER_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] INHIBIT_LAST = TIMER_WIDTH'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] SETUP_LAST   = TIMER_WIDTH'(DATA_SETUP_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] FIRST_LAST   = TIMER_WIDTH'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] XFER_LAST    = TIMER_WIDTH'(TRANSFER_TIMEOUT - 1);
    localparam logic [3:0]             STOP_IDX     = 4'(FRAME_LEN - 1);

    tx_state_e              state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d, timer_inc_s;
    logic [3:0]             bitcnt_q, bitcnt_d;
    frame_t                 frame_q, frame_d;
    logic                   cur_bit_q, cur_bit_d;
    logic                   drive_clk_q, drive_clk_d;
    logic                   drive_dat_q, drive_dat_d;
    logic                   busy_q, busy_d;
    logic                   sent_q, sent_d;
    logic                   err_q, err_d;
    line_sync_t             line_s;
    logic                   unused_edges_s;

    ps2_line_sync u_sync (
        .clk       (CLOCK_50),
        .reset     (reset),
        .ps2_clk_i (PS2_CLK),
        .ps2_dat_i (PS2_DAT),
        .sync_o    (line_s)
    );

    assign unused_edges_s = ^{line_s.clk_rise, line_s.dat_fall, line_s.dat_rise};
    assign timer_inc_s    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= TIMER_ZERO;
            bitcnt_q    <= 4'd0;
            frame_q     <= {FRAME_LEN{1'b0}};
            cur_bit_q   <= 1'b1;
            drive_clk_q <= 1'b0;
            drive_dat_q <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bitcnt_q    <= bitcnt_d;
            frame_q     <= frame_d;
            cur_bit_q   <= cur_bit_d;
            drive_clk_q <= drive_clk_d;
            drive_dat_q <= drive_dat_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
            err_q       <= err_d;
        end
    end

    // The transfer timer runs from the first device edge through ACK and bus idle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_inc_s;
        bitcnt_d  = bitcnt_q;
        frame_d   = frame_q;
        cur_bit_d = cur_bit_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = TIMER_ZERO;
                if (cmd_if.send_command) begin
                    frame_d  = build_frame(cmd_if.the_command);
                    bitcnt_d = 4'd0;
                    state_d  = ST_INHIBIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (timer_q >= INHIBIT_LAST) begin
                    state_d = ST_RTS;
                    timer_d = TIMER_ZERO;
                end else begin
                    state_d = ST_INHIBIT;
                end
            end
            ST_RTS: begin
                if (timer_q >= SETUP_LAST) begin
                    state_d = ST_WAIT_EDGE;
                    timer_d = TIMER_ZERO;
                end else begin
                    state_d = ST_RTS;
                end
            end
            ST_WAIT_EDGE: begin
                if (line_s.clk_fall) begin
                    cur_bit_d = frame_q[0];
                    bitcnt_d  = 4'd1;
                    timer_d   = TIMER_ZERO;
                    state_d   = ST_TX;
                end else if (timer_q >= FIRST_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_WAIT_EDGE;
                end
            end
            ST_TX: begin
                if (timer_q >= XFER_LAST) begin
                    state_d = ST_ERR;
                end else if (line_s.clk_fall) begin
                    cur_bit_d = frame_q[bitcnt_q];
                    bitcnt_d  = bitcnt_q + 4'd1;
                    state_d   = (bitcnt_q == STOP_IDX) ? ST_WAIT_ACK : ST_TX;
                end else begin
                    state_d = ST_TX;
                end
            end
            ST_WAIT_ACK: begin
                if (timer_q >= XFER_LAST) begin
                    state_d = ST_ERR;
                end else if (line_s.clk_fall) begin
                    state_d = line_s.dat ? ST_ERR : ST_WAIT_IDLE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_IDLE: begin
                if (timer_q >= XFER_LAST) begin
                    state_d = ST_ERR;
                end else if (line_s.clk && line_s.dat) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                timer_d = TIMER_ZERO;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                timer_d = TIMER_ZERO;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = TIMER_ZERO;
            end
        endcase
    end

    // Open-drain drive: a 1 here pulls the line low, 0 releases it.
    always_comb begin
        drive_clk_d = 1'b0;
        drive_dat_d = 1'b0;
        busy_d      = (state_q != ST_IDLE);
        sent_d      = (state_q == ST_DONE);
        err_d       = (state_q == ST_ERR);
        case (state_q)
            ST_INHIBIT: begin
                drive_clk_d = 1'b1;
            end
            ST_RTS: begin
                drive_clk_d = 1'b1;
                drive_dat_d = 1'b1;
            end
            ST_WAIT_EDGE: begin
                drive_dat_d = 1'b1;
            end
            ST_TX: begin
                drive_dat_d = ~cur_bit_q;
            end
            default: begin
                drive_clk_d = 1'b0;
                drive_dat_d = 1'b0;
            end
        endcase
    end

    assign PS2_CLK = drive_clk_q ? 1'b0 : 1'bz;
    assign PS2_DAT = drive_dat_q ? 1'b0 : 1'bz;

    assign cmd_if.busy                          = busy_q;
    assign cmd_if.command_was_sent              = sent_q;
    assign cmd_if.error_communication_timed_out = err_q;
endmodule
